// File: rtl/approx_err_accum_if.sv
// Operand/approximate-product stream feeding the error accumulator.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready handshake; a pair moves when both are high.
interface approx_err_accum_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] r_apx;

    // Producer side (multiplier under test / stimulus)
    modport master (output in_valid, a, b, r_apx, input in_ready);
    // Consumer side (approx_err_accum)
    modport slave  (input in_valid, a, b, r_apx, output in_ready);
endinterface

// File: rtl/approx_err_accum.sv
// Error statistics over SAMPLES (a,b,r_apx) pairs vs exact a*b; optional signed bias sum (ERR_SIGNED_SUM_EN).
// Latency: accept -> stats update 2 cycles; done pulse 3 cycles after the last accept.
// Backpressure: in_ready only in RUN while fewer than SAMPLES pairs taken; full rate, no bubbles.
module approx_err_accum #(
    parameter  int SAMPLES = 256,
    parameter  int ACC_W   = 32,
    localparam int CW      = $clog2(SAMPLES + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    approx_err_accum_if.slave       in_if,
    input  logic                    start_i,
    input  logic                    abort_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [CW-1:0]           err_cnt_o,
    output logic [ACC_W-1:0]        sum_abs_err_o,
`ifdef ERR_SIGNED_SUM_EN
    output logic signed [ACC_W-1:0] sum_err_o,
`endif
    output logic [15:0]             max_abs_err_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic               drain_q;
    logic               in_ready_q;
    logic               busy_q;
    logic               done_q;

    logic               s1_vld_q;
    logic signed [16:0] s1_d_q;
    logic signed [16:0] s1_d_d;
    logic [15:0]        exact;

    logic [CW-1:0]      err_cnt_q, err_cnt_d;
    logic [ACC_W-1:0]   sum_abs_q, sum_abs_d;
    logic [15:0]        max_abs_q, max_abs_d;
    logic [15:0]        ae;
    logic [ACC_W:0]     abs_sum_ext;

    logic               accept;
    logic               start_act;
    logic               abort_act;

    // in_ready_q is only ever set in RUN, so it doubles as the RUN qualifier.
    assign accept    = in_if.in_valid & in_ready_q & ~abort_i;
    assign start_act = start_i & (state_q == S_IDLE);
    assign abort_act = abort_i & ((state_q == S_RUN) | (state_q == S_DRAIN));

    assign in_if.in_ready = in_ready_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign err_cnt_o      = err_cnt_q;
    assign sum_abs_err_o  = sum_abs_q;
    assign max_abs_err_o  = max_abs_q;

    // Control FSM: window counting, drain and the one-cycle done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            drain_q    <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q    <= S_RUN;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (abort_i) begin
                        state_q    <= S_IDLE;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end else if (accept) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(SAMPLES - 1)) begin
                            in_ready_q <= 1'b0;
                            drain_q    <= 1'b0;
                            state_q    <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (abort_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (drain_q) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Stage 1 arithmetic: exact product and signed difference (exact folded into d).
    always_comb begin
        exact  = 16'(in_if.a * in_if.b);
        s1_d_d = $signed({1'b0, exact}) - $signed({1'b0, in_if.r_apx});
    end

    // Stage 1 register; abort suppresses accept, which flushes the valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_d_q   <= '0;
        end else begin
            s1_vld_q <= accept;
            if (accept) begin
                s1_d_q <= s1_d_d;
            end
        end
    end

    // Stage 2 next values: magnitude, error count, saturating sum, running max.
    always_comb begin
        ae          = s1_d_q[16] ? 16'(-s1_d_q) : s1_d_q[15:0];
        err_cnt_d   = err_cnt_q + CW'(ae != 16'd0);
        abs_sum_ext = {1'b0, sum_abs_q} + (ACC_W + 1)'(ae);
        sum_abs_d   = abs_sum_ext[ACC_W] ? '1 : abs_sum_ext[ACC_W-1:0];
        max_abs_d   = (ae > max_abs_q) ? ae : max_abs_q;
    end

    // Stage 2 result registers: cleared by an honoured start, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
            sum_abs_q <= '0;
            max_abs_q <= '0;
        end else if (start_act) begin
            err_cnt_q <= '0;
            sum_abs_q <= '0;
            max_abs_q <= '0;
        end else if (s1_vld_q && !abort_act) begin
            err_cnt_q <= err_cnt_d;
            sum_abs_q <= sum_abs_d;
            max_abs_q <= max_abs_d;
        end
    end

`ifdef ERR_SIGNED_SUM_EN
    logic [ACC_W-1:0] sum_err_q, sum_err_d;
    logic [ACC_W:0]   ssum_ext;

    assign sum_err_o = $signed(sum_err_q);

    // Signed bias sum with clamping at the two's-complement limits.
    always_comb begin
        ssum_ext  = {sum_err_q[ACC_W-1], sum_err_q} + {{(ACC_W - 16){s1_d_q[16]}}, s1_d_q};
        sum_err_d = ssum_ext[ACC_W-1:0];
        if (ssum_ext[ACC_W] != ssum_ext[ACC_W-1]) begin
            sum_err_d = ssum_ext[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
        end
    end

    // Signed sum register, same timing and clearing as the absolute sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_err_q <= '0;
        end else if (start_act) begin
            sum_err_q <= '0;
        end else if (s1_vld_q && !abort_act) begin
            sum_err_q <= sum_err_d;
        end
    end
`endif

endmodule

// File: tb/tb_approx_err_accum.sv
// Scoreboarded bench: two instances (SAMPLES=4, ACC_W=32 and ACC_W=17) sharing clock/reset.
// Expected window results are queued at stimulus time and popped on each done pulse.
// Directed vectors: exact window, error window, valid gaps, saturation, abort, async reset.
module tb_approx_err_accum;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    approx_err_accum_if if0();
    approx_err_accum_if if1();

    logic        start0, abort0, start1, abort1;
    logic        busy0, busy1, done0, done1;
    logic [2:0]  err0, err1;
    logic [31:0] sum0;
    logic [16:0] sum1;
    logic [15:0] max0, max1;
`ifdef ERR_SIGNED_SUM_EN
    logic signed [31:0] serr0;
    logic signed [16:0] serr1;
`endif

    approx_err_accum #(.SAMPLES(4), .ACC_W(32)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_if(if0), .start_i(start0), .abort_i(abort0),
        .busy_o(busy0), .done_o(done0), .err_cnt_o(err0), .sum_abs_err_o(sum0),
`ifdef ERR_SIGNED_SUM_EN
        .sum_err_o(serr0),
`endif
        .max_abs_err_o(max0));

    approx_err_accum #(.SAMPLES(4), .ACC_W(17)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_if(if1), .start_i(start1), .abort_i(abort1),
        .busy_o(busy1), .done_o(done1), .err_cnt_o(err1), .sum_abs_err_o(sum1),
`ifdef ERR_SIGNED_SUM_EN
        .sum_err_o(serr1),
`endif
        .max_abs_err_o(max1));

    typedef struct {
        longint err;
        longint sum;
        longint mx;
        longint serr;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   dcnt0  = 0;
    int   dcnt1  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int w, input longint e, input longint s, input longint m, input longint se);
        exp_t x;
        x.err = e; x.sum = s; x.mx = m; x.serr = se;
        if (w == 0) q0.push_back(x);
        else        q1.push_back(x);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t x;
        if (done0 === 1'b1) begin
            dcnt0++;
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done0: got done with empty scoreboard expected none");
            end else begin
                x = q0.pop_front();
                chk("dut0_err_cnt", longint'(err0), x.err);
                chk("dut0_sum_abs", longint'(sum0), x.sum);
                chk("dut0_max_abs", longint'(max0), x.mx);
`ifdef ERR_SIGNED_SUM_EN
                chk("dut0_sum_err", longint'(serr0), x.serr);
`endif
            end
        end
        if (done1 === 1'b1) begin
            dcnt1++;
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done1: got done with empty scoreboard expected none");
            end else begin
                x = q1.pop_front();
                chk("dut1_err_cnt", longint'(err1), x.err);
                chk("dut1_sum_abs", longint'(sum1), x.sum);
                chk("dut1_max_abs", longint'(max1), x.mx);
`ifdef ERR_SIGNED_SUM_EN
                chk("dut1_sum_err", longint'(serr1), x.serr);
`endif
            end
        end
    end

    task automatic pulse_start(input int w);
        @(negedge clk);
        if (w == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // Present one pair and hold it until the DUT takes it; returns just after the accepting edge.
    task automatic send(input int w, input logic [7:0] a, input logic [7:0] b, input logic [15:0] r);
        int   guard;
        logic rdy;
        guard = 0;
        @(negedge clk);
        if (w == 0) begin if0.a = a; if0.b = b; if0.r_apx = r; if0.in_valid = 1'b1; end
        else        begin if1.a = a; if1.b = b; if1.r_apx = r; if1.in_valid = 1'b1; end
        rdy = (w == 0) ? if0.in_ready : if1.in_ready;
        while (rdy !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
            rdy = (w == 0) ? if0.in_ready : if1.in_ready;
        end
        if (rdy !== 1'b1) begin
            chk("send_timeout", 0, 1);
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drop();
        if0.in_valid = 1'b0;
        if1.in_valid = 1'b0;
    endtask

    task automatic wait_done(input int w, input int budget);
        int c;
        int n;
        c = (w == 0) ? dcnt0 : dcnt1;
        n = 0;
        while (((w == 0) ? dcnt0 : dcnt1) == c && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (((w == 0) ? dcnt0 : dcnt1) == c) chk("done_timeout", 0, 1);
    endtask

    logic pat [12];
    int   acc, last, done_at;
    logic rdy_after;
    int   d0;

    initial begin
        rst_n = 1'b0;
        start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
        if0.in_valid = 1'b0; if0.a = '0; if0.b = '0; if0.r_apx = '0;
        if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.r_apx = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", longint'(busy0), 0);
        chk("rst_ready", longint'(if0.in_ready), 0);
        chk("rst_err", longint'(err0), 0);
        chk("rst_sum", longint'(sum0), 0);
        rst_n = 1'b1;

        // Exact products: no error at all.
        push(0, 0, 0, 0, 0);
        pulse_start(0);
        chk("run_busy", longint'(busy0), 1);
        send(0, 8'd3, 8'd5, 16'd15);
        send(0, 8'd255, 8'd255, 16'd65025);
        send(0, 8'd0, 8'd7, 16'd0);
        send(0, 8'd16, 8'd16, 16'd256);
        drop();
        wait_done(0, 20);
        chk("idle_busy", longint'(busy0), 0);

        // Mixed under/over-estimates.
        push(0, 3, 65031, 65025, 65027);
        pulse_start(0);
        send(0, 8'd255, 8'd255, 16'd0);
        send(0, 8'd10, 8'd10, 16'd96);
        send(0, 8'd2, 8'd3, 16'd6);
        send(0, 8'd1, 8'd1, 16'd3);
        drop();
        wait_done(0, 20);
        chk("hold_err", longint'(err0), 3);

        // Gapped valid: exactly four accepts, ready drops, done 3 cycles later.
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        push(0, 4, 4, 1, -4);
        pulse_start(0);
        if0.a = 8'd2; if0.b = 8'd3; if0.r_apx = 16'd7;
        acc = 0; last = -10; done_at = -1; rdy_after = 1'bx;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if0.in_valid = pat[i];
            if (i == last + 1) rdy_after = if0.in_ready;
            if (pat[i] && if0.in_ready === 1'b1) begin
                acc++;
                if (acc == 4) last = i;
            end
            if (done0 === 1'b1 && done_at < 0) done_at = i;
        end
        drop();
        chk("gap_accepts", acc, 4);
        chk("gap_ready_after", longint'(rdy_after), 0);
        chk("gap_done_cycle", done_at, last + 3);

        // Saturating absolute sum on the 17-bit instance.
        push(1, 4, 131071, 65025, 65535);
        pulse_start(1);
        for (int i = 0; i < 4; i++) send(1, 8'd255, 8'd255, 16'd0);
        drop();
        wait_done(1, 20);

        // Abort after two accepts: partial results kept, no done.
        d0 = dcnt0;
        pulse_start(0);
        send(0, 8'd255, 8'd255, 16'd0);
        send(0, 8'd10, 8'd10, 16'd96);
        drop();
        repeat (2) @(negedge clk);
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        chk("abort_busy", longint'(busy0), 0);
        chk("abort_ready", longint'(if0.in_ready), 0);
        repeat (6) @(negedge clk);
        chk("abort_no_done", dcnt0, d0);
        chk("abort_err", longint'(err0), 2);
        chk("abort_sum", longint'(sum0), 65029);
        chk("abort_max", longint'(max0), 65025);
`ifdef ERR_SIGNED_SUM_EN
        chk("abort_sum_err", longint'(serr0), 65029);
`endif
        pulse_start(0);
        chk("restart_err", longint'(err0), 0);
        chk("restart_sum", longint'(sum0), 0);
        chk("restart_max", longint'(max0), 0);
        push(0, 0, 0, 0, 0);
        send(0, 8'd3, 8'd5, 16'd15);
        send(0, 8'd255, 8'd255, 16'd65025);
        send(0, 8'd0, 8'd7, 16'd0);
        send(0, 8'd16, 8'd16, 16'd256);
        drop();
        wait_done(0, 20);

        // Asynchronous reset mid-window.
        d0 = dcnt0;
        pulse_start(0);
        send(0, 8'd255, 8'd255, 16'd0);
        send(0, 8'd10, 8'd10, 16'd96);
        drop();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", longint'(busy0), 0);
        chk("arst_ready", longint'(if0.in_ready), 0);
        chk("arst_err", longint'(err0), 0);
        chk("arst_sum", longint'(sum0), 0);
        chk("arst_max", longint'(max0), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("arst_no_done", dcnt0, d0);
        push(0, 3, 65031, 65025, 65027);
        pulse_start(0);
        send(0, 8'd255, 8'd255, 16'd0);
        send(0, 8'd10, 8'd10, 16'd96);
        send(0, 8'd2, 8'd3, 16'd6);
        send(0, 8'd1, 8'd1, 16'd3);
        drop();
        wait_done(0, 20);

        repeat (3) @(negedge clk);
        chk("sb0_empty", q0.size(), 0);
        chk("sb1_empty", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
